// File: rtl/cp_regfile_sb.sv
// Register file with two write ports, NRD combinational read ports and a per-register busy scoreboard.
// Optional write-to-read forwarding is enabled by defining CP_REGFILE_SB_BYPASS_EN.
module cp_regfile_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr_i,
  output logic [NRD*XLEN-1:0] rs_data_o,
  output logic [NRD-1:0]      rs_busy_o,
  input  logic [1:0]          wr_we_i,
  input  logic [2*AW-1:0]     wr_addr_i,
  input  logic [2*XLEN-1:0]   wr_data_i,
  input  logic                rsv_valid_i,
  input  logic [AW-1:0]       rsv_addr_i,
  output logic [AW:0]         busy_cnt_o
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  logic [AW-1:0]   wa0, wa1;
  logic [XLEN-1:0] wd0, wd1;
  logic            w0_hit, w1_hit, rsv_hit;
  logic            set_new, clr0, clr1;
  logic [AW:0]     cnt_inc, cnt_dec;
  logic [AW-1:0]   rd_a;

  assign wa0     = wr_addr_i[0 +: AW];
  assign wa1     = wr_addr_i[AW +: AW];
  assign wd0     = wr_data_i[0 +: XLEN];
  assign wd1     = wr_data_i[XLEN +: XLEN];
  assign w0_hit  = wr_we_i[0] && (wa0 != '0);
  assign w1_hit  = wr_we_i[1] && (wa1 != '0);
  assign rsv_hit = rsv_valid_i && (rsv_addr_i != '0);

  // Writes clear their busy bit first, a same-cycle reserve then re-sets it (new producer wins).
  always_comb begin
    busy_nxt = busy;
    if (w0_hit) busy_nxt[wa0] = 1'b0;
    if (w1_hit) busy_nxt[wa1] = 1'b0;
    if (rsv_hit) busy_nxt[rsv_addr_i] = 1'b1;
  end

  // Counter delta: a clear only counts if the bit was set, is not re-reserved, and is not a duplicate port.
  always_comb begin
    set_new = rsv_hit && !busy[rsv_addr_i];
    clr0    = w0_hit && busy[wa0] && !(rsv_hit && (rsv_addr_i == wa0));
    clr1    = w1_hit && busy[wa1] && !(rsv_hit && (rsv_addr_i == wa1))
              && !(w0_hit && (wa0 == wa1));
    cnt_inc = {{AW{1'b0}}, set_new};
    cnt_dec = {{AW{1'b0}}, clr0} + {{AW{1'b0}}, clr1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_cnt_o <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_cnt_o <= busy_cnt_o + cnt_inc - cnt_dec;
    end
  end

  // Port 1 is issued last so its non-blocking update overrides port 0 on an address clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (w0_hit) regs[wa0] <= wd0;
      if (w1_hit) regs[wa1] <= wd1;
    end
  end

  always_comb begin
    rs_data_o = '0;
    rs_busy_o = '0;
    rd_a      = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_a = rs_addr_i[k*AW +: AW];
      rs_data_o[k*XLEN +: XLEN] = regs[rd_a];
      rs_busy_o[k]              = busy[rd_a];
`ifdef CP_REGFILE_SB_BYPASS_EN
      if (w1_hit && (wa1 == rd_a)) begin
        rs_data_o[k*XLEN +: XLEN] = wd1;
        rs_busy_o[k]              = rsv_hit && (rsv_addr_i == rd_a);
      end else if (w0_hit && (wa0 == rd_a)) begin
        rs_data_o[k*XLEN +: XLEN] = wd0;
        rs_busy_o[k]              = rsv_hit && (rsv_addr_i == rd_a);
      end
`endif
    end
  end

endmodule

// File: tb/tb_cp_regfile_sb.sv
// Randomized and directed self-checking bench for cp_regfile_sb against a register/scoreboard model.
module tb_cp_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NRD*AW-1:0]   rs_addr_i;
  logic [NRD*XLEN-1:0] rs_data_o;
  logic [NRD-1:0]      rs_busy_o;
  logic [1:0]          wr_we_i;
  logic [2*AW-1:0]     wr_addr_i;
  logic [2*XLEN-1:0]   wr_data_i;
  logic                rsv_valid_i;
  logic [AW-1:0]       rsv_addr_i;
  logic [AW:0]         busy_cnt_o;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  always #5 clk = ~clk;

  cp_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst(rst),
    .rs_addr_i(rs_addr_i), .rs_data_o(rs_data_o), .rs_busy_o(rs_busy_o),
    .wr_we_i(wr_we_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rsv_valid_i(rsv_valid_i), .rsv_addr_i(rsv_addr_i),
    .busy_cnt_o(busy_cnt_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int countBusy();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Writes land in port order so port 1 overrides; reserve is applied after the clears.
  task automatic modelUpdate();
    logic [AW-1:0] a;
    if (rst) begin
      modelReset();
    end else begin
      for (int p = 0; p < 2; p++) begin
        a = wr_addr_i[p*AW +: AW];
        if (wr_we_i[p] && a != 0) begin
          m_regs[a] = wr_data_i[p*XLEN +: XLEN];
          m_busy[a] = 1'b0;
        end
      end
      if (rsv_valid_i && rsv_addr_i != 0) m_busy[rsv_addr_i] = 1'b1;
    end
  endtask

  task automatic checkAll(input string tag);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] ed;
    logic            eb;
    for (int k = 0; k < NRD; k++) begin
      a  = rs_addr_i[k*AW +: AW];
      ed = m_regs[a];
      eb = m_busy[a];
`ifdef CP_REGFILE_SB_BYPASS_EN
      for (int p = 0; p < 2; p++) begin
        if (!rst && a != 0 && wr_we_i[p] && wr_addr_i[p*AW +: AW] == a) begin
          ed = wr_data_i[p*XLEN +: XLEN];
          eb = rsv_valid_i && rsv_addr_i == a;
        end
      end
`endif
      checkOutput($sformatf("%s_data%0d", tag, k), 64'(rs_data_o[k*XLEN +: XLEN]), 64'(ed));
      checkOutput($sformatf("%s_busy%0d", tag, k), 64'(rs_busy_o[k]), 64'(eb));
    end
    checkOutput($sformatf("%s_cnt", tag), 64'(busy_cnt_o), 64'(countBusy()));
  endtask

  task automatic setIdle();
    wr_we_i = '0; wr_addr_i = '0; wr_data_i = '0;
    rsv_valid_i = 1'b0; rsv_addr_i = '0; rs_addr_i = '0;
  endtask

  task automatic setWrite(input int p, input int a, input logic [XLEN-1:0] d);
    wr_we_i[p] = 1'b1;
    wr_addr_i[p*AW +: AW] = AW'(a);
    wr_data_i[p*XLEN +: XLEN] = d;
  endtask

  task automatic setRead(input int k, input int a);
    rs_addr_i[k*AW +: AW] = AW'(a);
  endtask

  task automatic setReserve(input int a);
    rsv_valid_i = 1'b1;
    rsv_addr_i  = AW'(a);
  endtask

  task automatic applyStimulus();
    wr_we_i = 2'($urandom_range(0, 3));
    for (int p = 0; p < 2; p++) begin
      wr_addr_i[p*AW +: AW]     = AW'($urandom_range(0, 7));
      wr_data_i[p*XLEN +: XLEN] = $urandom;
    end
    for (int k = 0; k < NRD; k++) rs_addr_i[k*AW +: AW] = AW'($urandom_range(0, 7));
    rsv_valid_i = 1'($urandom_range(0, 1));
    rsv_addr_i  = AW'($urandom_range(0, 7));
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    setIdle();
    modelReset();
    #2;
    checkAll("rst_init");
    checkOutput("rst_init_cnt0", 64'(busy_cnt_o), 64'd0);

    // Activity while reset is held must be ignored.
    setWrite(0, 5, 32'hFFFF_0000);
    setReserve(2);
    tick();
    tick();
    settle();
    checkAll("rst_hold");
    rst = 1'b0;
    setIdle();
    tick();
    settle();
    checkAll("post_rst");

    // Simple write then read back.
    tick();
    setIdle();
    setWrite(0, 5, 32'hDEADBEEF);
    setRead(0, 5);
    tick();
    setIdle();
    setRead(0, 5);
    settle();
    checkAll("req030");
    checkOutput("req030_data", 64'(rs_data_o[31:0]), 64'hDEADBEEF);
    checkOutput("req030_busy", 64'(rs_busy_o[0]), 64'd0);

    // Register 0 is hardwired to zero and cannot be reserved.
    tick();
    setIdle();
    setWrite(0, 0, 32'h12345678);
    setRead(0, 0);
    settle();
    checkOutput("req031_rd0_same", 64'(rs_data_o[31:0]), 64'd0);
    tick();
    setIdle();
    setReserve(0);
    setRead(0, 0);
    settle();
    checkOutput("req031_rd0_next", 64'(rs_data_o[31:0]), 64'd0);
    tick();
    setIdle();
    settle();
    checkOutput("req031_cnt", 64'(busy_cnt_o), 64'd0);
    checkAll("req031");

    // Port 1 wins a same-address write.
    tick();
    setIdle();
    setWrite(0, 7, 32'h1);
    setWrite(1, 7, 32'h2);
    tick();
    setIdle();
    setRead(1, 7);
    settle();
    checkOutput("req032_data", 64'(rs_data_o[63:32]), 64'h2);

    // Scoreboard reserve/clear sequence.
    tick();
    setIdle();
    setReserve(3);
    tick();
    setIdle();
    setReserve(4);
    tick();
    setIdle();
    setRead(0, 3);
    setRead(1, 4);
    settle();
    checkAll("req033_a");
    checkOutput("req033_cnt2", 64'(busy_cnt_o), 64'd2);
    checkOutput("req033_busy34", 64'(rs_busy_o), 64'b11);
    tick();
    setIdle();
    setReserve(3);
    setWrite(0, 3, 32'hA);
    tick();
    setIdle();
    setRead(0, 3);
    settle();
    checkOutput("req033_cnt_keep", 64'(busy_cnt_o), 64'd2);
    checkOutput("req033_data3", 64'(rs_data_o[31:0]), 64'hA);
    checkOutput("req033_busy3", 64'(rs_busy_o[0]), 64'd1);
    tick();
    setIdle();
    setWrite(1, 4, 32'h44);
    tick();
    setIdle();
    settle();
    checkOutput("req033_cnt1", 64'(busy_cnt_o), 64'd1);
    checkAll("req033_b");
    tick();
    setIdle();
    setWrite(0, 3, 32'h33);
    tick();

    // Same-cycle read of a register being written.
    setIdle();
    setWrite(0, 9, 32'h55);
    setRead(0, 9);
    settle();
`ifdef CP_REGFILE_SB_BYPASS_EN
    checkOutput("req034_fwd", 64'(rs_data_o[31:0]), 64'h55);
`else
    checkOutput("req034_nofwd", 64'(rs_data_o[31:0]), 64'h0);
`endif
    checkAll("req034");
    tick();

    repeat (400) begin
      applyStimulus();
      settle();
      checkAll("rnd");
      tick();
    end

    // Asynchronous reset in the middle of a cycle.
    for (int a = 1; a <= 6; a++) begin
      setIdle();
      setReserve(a);
      tick();
    end
    setIdle();
    setRead(0, 3);
    setRead(1, 6);
    #1;
    checkOutput("req035_pre_cnt", 64'(busy_cnt_o), 64'(countBusy()));
    #1;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("req035_cnt", 64'(busy_cnt_o), 64'd0);
    checkOutput("req035_busy", 64'(rs_busy_o), 64'd0);
    checkOutput("req035_data", 64'(rs_data_o), 64'd0);
    checkAll("req035");
    setWrite(1, 6, 32'h66);
    setReserve(5);
    tick();
    settle();
    checkAll("req035_hold");
    rst = 1'b0;
    setIdle();
    setRead(0, 6);
    setRead(1, 5);
    tick();
    settle();
    checkAll("req035_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cp_regfile_sb.md
CP_REGFILE_SB -- requirements
Module: cp_regfile_sb

Interface
REQ-001 XLEN, 32, data width of each register in bits.
REQ-002 NREGS, 32, number of architectural registers (power of two, at least 4); AW = clog2(NREGS).
REQ-003 NRD, 2, number of independent read ports (1..4).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rs_addr_i  input  NRD*AW  read addresses, port k at bits [k*AW +: AW].
REQ-007 rs_data_o  output  NRD*XLEN  read data, port k at [k*XLEN +: XLEN].
REQ-008 rs_busy_o  output  NRD  scoreboard pending bit of each read address.
REQ-009 wr_we_i  input  2  write enables, write ports 0 and 1.
REQ-010 wr_addr_i  input  2*AW  write addresses.
REQ-011 wr_data_i  input  2*XLEN  write data.
REQ-012 rsv_valid_i  input  1  reserve request: mark rsv_addr_i pending.
REQ-013 rsv_addr_i  input  AW  register being reserved.
REQ-014 busy_cnt_o  output  AW+1  count of currently pending registers.

Function
REQ-015 Reads SHALL be combinational from rs_addr_i; register 0 SHALL always read 0 with rs_busy_o low.
REQ-016 A write with wr_we_i[p]=1 and address nonzero SHALL update the register on the next clk edge; writes to register 0 SHALL be discarded.
REQ-017 If both write ports target the same nonzero address in one cycle, port 1 data SHALL win.
REQ-018 The scoreboard SHALL hold one busy bit per register; rsv_valid_i=1 with nonzero rsv_addr_i SHALL set that bit at the next edge.
REQ-019 An enabled write to a nonzero address SHALL clear that busy bit at the next edge.
REQ-020 Reserve and write to the same address in one cycle: the busy bit SHALL end set (reserve wins, new producer) and the data SHALL still update.
REQ-021 Reserve of an already-busy register SHALL leave it busy; write to a non-busy register SHALL leave it clear.
REQ-022 rs_busy_o SHALL reflect registered busy bits only (no same-cycle look-ahead of reserve or clear).
REQ-023 busy_cnt_o SHALL be a registered counter equal to the population count of busy bits, updated by +1/-1/-2/0 per edge consistent with REQ-018..REQ-021; it SHALL never exceed NREGS-1 nor underflow.

Reset
REQ-024 While rst is high all registers SHALL be 0, all busy bits 0, busy_cnt_o 0, independent of clk.
REQ-025 Writes and reserves presented while rst is high SHALL have no effect; first update occurs on the first clk edge after rst falls.
REQ-026 Reset asserted mid-operation SHALL discard all pending reservations immediately.

Configuration
REQ-027 Macro CP_REGFILE_SB_BYPASS_EN SHALL control write-to-read forwarding.
REQ-028 With CP_REGFILE_SB_BYPASS_EN defined, a read whose address matches an enabled same-cycle nonzero write SHALL return wr_data_i (port 1 priority) combinationally, and rs_busy_o for that port SHALL be 0 unless rsv_valid_i targets the same address.
REQ-029 Without the macro, reads SHALL return the stored value only; the new value is visible the cycle after the write.

Verification
REQ-030 After reset, write port 0 addr 5 data 0xDEADBEEF; next cycle read port 0 addr 5 -> 0xDEADBEEF, busy 0.
REQ-031 Write addr 0 data 0x12345678, read addr 0 -> 0x00000000; reserve addr 0 -> busy_cnt_o stays 0.
REQ-032 Both write ports addr 7, data 0x1 (port 0) and 0x2 (port 1) -> read addr 7 returns 0x2.
REQ-033 Reserve addr 3, then addr 4 -> busy_cnt_o 2, rs_busy_o high for 3 and 4; same-cycle reserve 3 + write 3 data 0xA -> busy stays, count 2, data 0xA; write 4 -> count 1.
REQ-034 With bypass defined, write addr 9 data 0x55 while reading addr 9 in same cycle -> rs_data_o 0x55; without, old value 0x0.
REQ-035 Reserve addrs 1..6, assert rst asynchronously mid-cycle -> busy_cnt_o and all rs_busy_o 0 and all reads 0 before the next clk edge.
